// File: rtl/umi_responder_pkg.sv
// rtl/umi_responder_pkg.sv - shared UMI widths and responder FSM state type
package ShellTypes;

  localparam int UMI_ADDR_WIDTH = 32;
  localparam int UMI_DATA_WIDTH = 512;
  localparam int UMI_MASK_WIDTH = UMI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'd0,
    RESP_GRANT = 2'd1,
    RESP_READ  = 2'd2,
    RESP_WRITE = 2'd3
  } umi_resp_state_e;

endpackage

// File: rtl/umi_responder_if.sv
// rtl/umi_responder_if.sv - UMI request/read/write bundle with initiator and responder views
interface umi_if;

  logic                                   umi_raise_in;
  logic                                   umi_write_in;
  logic [ShellTypes::UMI_ADDR_WIDTH-1:0]  umi_addr_in;
  logic [ShellTypes::UMI_ADDR_WIDTH-1:0]  umi_size_in;
  logic                                   umi_grant_out;
  logic [ShellTypes::UMI_DATA_WIDTH-1:0]  umi_rddata_out;
  logic                                   umi_rdrdy_out;
  logic                                   umi_rden_in;
  logic [ShellTypes::UMI_DATA_WIDTH-1:0]  umi_wrdata_in;
  logic [ShellTypes::UMI_MASK_WIDTH-1:0]  umi_wrmask_in;
  logic                                   umi_wren_in;
  logic                                   umi_wrrdy_out;

  modport master (
    output umi_raise_in, umi_write_in, umi_addr_in, umi_size_in,
    output umi_rden_in, umi_wrdata_in, umi_wrmask_in, umi_wren_in,
    input  umi_grant_out, umi_rddata_out, umi_rdrdy_out, umi_wrrdy_out
  );

  modport slave (
    input  umi_raise_in, umi_write_in, umi_addr_in, umi_size_in,
    input  umi_rden_in, umi_wrdata_in, umi_wrmask_in, umi_wren_in,
    output umi_grant_out, umi_rddata_out, umi_rdrdy_out, umi_wrrdy_out
  );

endinterface

// File: rtl/umi_responder_ram.sv
// rtl/umi_responder_ram.sv - single-port backing store, registered read, byte-enable write
module umi_resp_ram #(
  parameter int NUM_WORDS = 1024,
  parameter int DATA_W    = 512,
  parameter int AW        = $clog2(NUM_WORDS),
  parameter int BW        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [BW-1:0]     i_be,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Storage is never reset so contents survive an aborted transfer.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BW; b++) begin
          if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/umi_responder.sv
// rtl/umi_responder.sv - UMI memory responder; UMI_RESP_WRMASK_EN enables per-byte write suppress
module umi_responder
  import ShellTypes::*;
#(
  parameter int NUM_WORDS  = 1024,
  parameter int BEAT_BYTES = UMI_DATA_WIDTH / 8
) (
  input  logic clk,
  input  logic rst_n,
  umi_if.slave umi,
  output logic busy_out
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam int CW = UMI_ADDR_WIDTH + 1;

  umi_resp_state_e           r_state;
  logic                      r_grant;
  logic                      r_busy;
  logic                      r_wrrdy;
  logic                      r_write;
  logic [IW-1:0]             r_idx;
  logic [CW-1:0]             r_issue_left;
  logic [CW-1:0]             r_left;
  logic                      r_ram_vld;
  logic [UMI_DATA_WIDTH-1:0] r_fifo [2];
  logic                      r_wptr;
  logic                      r_rptr;
  logic [1:0]                r_cnt;

  logic [CW-1:0]             w_beats_raw;
  logic [CW-1:0]             w_beats;
  logic [IW-1:0]             w_start;
  logic                      w_rdrdy;
  logic                      w_pop;
  logic                      w_wr_hs;
  logic                      w_rd_phase;
  logic [1:0]                w_occ;
  logic                      w_issue;
  logic [UMI_MASK_WIDTH-1:0] w_be;
  logic [UMI_DATA_WIDTH-1:0] w_ram_rdata;

  // One extra bit so the round-up cannot overflow; zero size still moves one beat.
  assign w_beats_raw = ({1'b0, umi.umi_size_in} + CW'(BEAT_BYTES - 1)) / CW'(BEAT_BYTES);
  assign w_beats     = (w_beats_raw == '0) ? CW'(1) : w_beats_raw;
  assign w_start     = IW'(umi.umi_addr_in / UMI_ADDR_WIDTH'(BEAT_BYTES));

  assign w_rdrdy    = (r_cnt != 2'd0);
  assign w_pop      = w_rdrdy & umi.umi_rden_in;
  assign w_wr_hs    = r_wrrdy & umi.umi_wren_in;
  assign w_rd_phase = ((r_state == RESP_GRANT) && !r_write) || (r_state == RESP_READ);
  // Buffered plus in-flight beats never exceed the two skid slots.
  assign w_occ      = r_cnt + {1'b0, r_ram_vld};
  assign w_issue    = w_rd_phase && (r_issue_left != '0) && ((w_occ - {1'b0, w_pop}) < 2'd2);

`ifdef UMI_RESP_WRMASK_EN
  assign w_be = ~umi.umi_wrmask_in;
`else
  // Mask is folded in as a no-op so every byte is written.
  assign w_be = {UMI_MASK_WIDTH{1'b1}} | umi.umi_wrmask_in;
`endif

  umi_resp_ram #(
    .NUM_WORDS (NUM_WORDS),
    .DATA_W    (UMI_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_issue | w_wr_hs),
    .i_we    (w_wr_hs),
    .i_be    (w_be),
    .i_addr  (r_idx),
    .i_wdata (umi.umi_wrdata_in),
    .o_rdata (w_ram_rdata)
  );

  // Transaction FSM: latches the request, walks the word index, owns grant/busy/wrrdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RESP_IDLE;
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_wrrdy      <= 1'b0;
      r_write      <= 1'b0;
      r_idx        <= '0;
      r_issue_left <= '0;
      r_left       <= '0;
    end else begin
      case (r_state)
        RESP_IDLE: begin
          if (umi.umi_raise_in) begin
            r_state      <= RESP_GRANT;
            r_grant      <= 1'b1;
            r_busy       <= 1'b1;
            r_write      <= umi.umi_write_in;
            r_idx        <= w_start;
            r_issue_left <= w_beats;
            r_left       <= w_beats;
          end
        end
        RESP_GRANT: begin
          r_grant <= 1'b0;
          if (r_write) begin
            r_state <= RESP_WRITE;
            r_wrrdy <= 1'b1;
          end else begin
            r_state <= RESP_READ;
          end
          if (w_issue) begin
            r_idx        <= r_idx + IW'(1);
            r_issue_left <= r_issue_left - CW'(1);
          end
        end
        RESP_READ: begin
          if (w_issue) begin
            r_idx        <= r_idx + IW'(1);
            r_issue_left <= r_issue_left - CW'(1);
          end
          if (w_pop) begin
            r_left <= r_left - CW'(1);
            if (r_left == CW'(1)) begin
              r_state <= RESP_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        RESP_WRITE: begin
          if (w_wr_hs) begin
            r_idx  <= r_idx + IW'(1);
            r_left <= r_left - CW'(1);
            if (r_left == CW'(1)) begin
              r_state <= RESP_IDLE;
              r_wrrdy <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= RESP_IDLE;
      endcase
    end
  end

  // Two-entry read-ahead buffer fed by the registered RAM output one cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 2'd0;
      r_ram_vld <= 1'b0;
    end else begin
      r_ram_vld <= w_issue;
      if (r_ram_vld) begin
        r_fifo[r_wptr] <= w_ram_rdata;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, r_ram_vld} - {1'b0, w_pop};
    end
  end

  assign umi.umi_grant_out  = r_grant;
  assign umi.umi_rdrdy_out  = w_rdrdy;
  assign umi.umi_rddata_out = r_fifo[r_rptr];
  assign umi.umi_wrrdy_out  = r_wrrdy;
  assign busy_out           = r_busy;

endmodule

// File: tb/tb_umi_responder.sv
// tb/tb_umi_responder.sv - directed self-checking bench for umi_responder
module tb_umi_responder;
  import ShellTypes::*;

  typedef logic [UMI_DATA_WIDTH-1:0] data_t;

  localparam data_t D_A5 = {64{8'hA5}};
  localparam data_t D_5A = {64{8'h5A}};
  localparam data_t D_D1 = {64{8'hD1}};
  localparam data_t D_D2 = {64{8'hD2}};
  localparam data_t D_B1 = {64{8'hB1}};
  localparam data_t D_B2 = {64{8'hB2}};
  localparam data_t D_B3 = {64{8'hB3}};
  localparam data_t D_B4 = {64{8'hB4}};
  localparam data_t D_00 = {64{8'h00}};
  localparam data_t D_FF = {64{8'hFF}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   n_grant = 0;
  int   n_wrhs = 0;
  int   n_rdhs = 0;

  umi_if u_if();

  umi_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .umi      (u_if),
    .busy_out (busy)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.umi_grant_out) n_grant++;
      if (u_if.umi_wren_in && u_if.umi_wrrdy_out) n_wrhs++;
      if (u_if.umi_rden_in && u_if.umi_rdrdy_out) n_rdhs++;
    end
  end

  task automatic chk(input string tag, input data_t obs, input data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] size);
    u_if.umi_raise_in = 1'b1;
    u_if.umi_write_in = wr;
    u_if.umi_addr_in  = addr;
    u_if.umi_size_in  = size;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] size,
                          input data_t d [4], input int n);
    req(1'b1, addr, size);
    tick();
    u_if.umi_raise_in  = 1'b0;
    u_if.umi_wren_in   = 1'b1;
    u_if.umi_wrdata_in = d[0];
    tick();
    for (int i = 0; i < n; i++) begin
      u_if.umi_wrdata_in = d[i];
      tick();
    end
    u_if.umi_wren_in = 1'b0;
  endtask

  task automatic read_one(input logic [31:0] addr, output data_t d, output logic g);
    req(1'b0, addr, 32'd64);
    tick();
    g = u_if.umi_grant_out;
    u_if.umi_raise_in = 1'b0;
    u_if.umi_rden_in  = 1'b1;
    tick();
    tick();
    d = u_if.umi_rddata_out;
    tick();
    u_if.umi_rden_in = 1'b0;
  endtask

  data_t wd [4];
  data_t rd;
  data_t mexp;
  logic  g;
  int    base_rd;
  int    base_gr;

  initial begin
    u_if.umi_raise_in  = 1'b0;
    u_if.umi_write_in  = 1'b0;
    u_if.umi_addr_in   = '0;
    u_if.umi_size_in   = '0;
    u_if.umi_rden_in   = 1'b0;
    u_if.umi_wrdata_in = '0;
    u_if.umi_wrmask_in = '0;
    u_if.umi_wren_in   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_grant", u_if.umi_grant_out, 1'b0);
    chk("rst_rdrdy", u_if.umi_rdrdy_out, 1'b0);
    chk("rst_wrrdy", u_if.umi_wrrdy_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rddata", u_if.umi_rddata_out, '0);
    rst_n = 1'b1;
    tick();

    // Two-beat write at 0x0
    req(1'b1, 32'h0, 32'd128);
    tick();
    chk("wr_grant", u_if.umi_grant_out, 1'b1);
    chk("wr_busy", busy, 1'b1);
    u_if.umi_raise_in  = 1'b0;
    u_if.umi_wren_in   = 1'b1;
    u_if.umi_wrdata_in = D_A5;
    tick();
    chk("wr_wrrdy", u_if.umi_wrrdy_out, 1'b1);
    chk("wr_grant_low", u_if.umi_grant_out, 1'b0);
    tick();
    chk("wr_wrrdy_b1", u_if.umi_wrrdy_out, 1'b1);
    u_if.umi_wrdata_in = D_5A;
    tick();
    u_if.umi_wren_in = 1'b0;
    chk("wr_idle_wrrdy", u_if.umi_wrrdy_out, 1'b0);
    chk("wr_idle_busy", busy, 1'b0);
    chk("wr_grants", 32'(n_grant), 32'd1);
    chk("wr_handshakes", 32'(n_wrhs), 32'd2);

    // Two-beat read back, first beat two cycles after grant
    req(1'b0, 32'h0, 32'd128);
    tick();
    chk("rd_grant", u_if.umi_grant_out, 1'b1);
    u_if.umi_raise_in = 1'b0;
    u_if.umi_rden_in  = 1'b1;
    tick();
    chk("rd_rdrdy_g1", u_if.umi_rdrdy_out, 1'b0);
    tick();
    chk("rd_rdrdy_g2", u_if.umi_rdrdy_out, 1'b1);
    chk("rd_beat0", u_if.umi_rddata_out, D_A5);
    tick();
    chk("rd_beat1", u_if.umi_rddata_out, D_5A);
    tick();
    chk("rd_idle_rdrdy", u_if.umi_rdrdy_out, 1'b0);
    chk("rd_idle_busy", busy, 1'b0);
    u_if.umi_rden_in = 1'b0;

    // Wrap: write at last word, second beat lands in word 0
    wd = '{D_D1, D_D2, D_00, D_00};
    do_write(32'h0000_FFC0, 32'd128, wd, 2);
    read_one(32'h0, rd, g);
    chk("wrap_word0", rd, D_D2);
    read_one(32'h0000_FFC0, rd, g);
    chk("wrap_word_last", rd, D_D1);

    // Three-beat read with rden toggling
    wd = '{D_B1, D_B2, D_B3, D_B4};
    do_write(32'h100, 32'd256, wd, 4);
    base_rd = n_rdhs;
    req(1'b0, 32'h100, 32'd192);
    tick();
    u_if.umi_raise_in = 1'b0;
    u_if.umi_rden_in  = 1'b1;
    tick();
    u_if.umi_rden_in = 1'b0;
    tick();
    chk("tog_rdy0", u_if.umi_rdrdy_out, 1'b1);
    chk("tog_beat0", u_if.umi_rddata_out, D_B1);
    u_if.umi_rden_in = 1'b1;
    tick();
    chk("tog_beat1", u_if.umi_rddata_out, D_B2);
    u_if.umi_rden_in = 1'b0;
    tick();
    chk("tog_beat1_stall", u_if.umi_rddata_out, D_B2);
    u_if.umi_rden_in = 1'b1;
    tick();
    chk("tog_beat2", u_if.umi_rddata_out, D_B3);
    u_if.umi_rden_in = 1'b0;
    tick();
    chk("tog_beat2_stall", u_if.umi_rddata_out, D_B3);
    u_if.umi_rden_in = 1'b1;
    tick();
    chk("tog_idle_rdrdy", u_if.umi_rdrdy_out, 1'b0);
    chk("tog_idle_busy", busy, 1'b0);
    chk("tog_beats", 32'(n_rdhs - base_rd), 32'd3);
    u_if.umi_rden_in = 1'b0;

    // Byte mask over a zeroed word
    wd = '{D_00, D_00, D_00, D_00};
    do_write(32'h200, 32'd64, wd, 1);
    wd = '{D_FF, D_00, D_00, D_00};
    u_if.umi_wrmask_in = 64'h1;
    do_write(32'h200, 32'd64, wd, 1);
    u_if.umi_wrmask_in = '0;
    read_one(32'h200, rd, g);
`ifdef UMI_RESP_WRMASK_EN
    mexp = {{63{8'hFF}}, 8'h00};
`else
    mexp = D_FF;
`endif
    chk("mask_word", rd, mexp);

    // Reset during beat 2 of a 4-beat read
    req(1'b0, 32'h100, 32'd256);
    tick();
    u_if.umi_raise_in = 1'b0;
    u_if.umi_rden_in  = 1'b1;
    tick();
    tick();
    chk("abort_beat0", u_if.umi_rddata_out, D_B1);
    tick();
    chk("abort_beat1", u_if.umi_rddata_out, D_B2);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {u_if.umi_grant_out, u_if.umi_rdrdy_out, u_if.umi_wrrdy_out, busy}, 4'b0000);
    chk("abort_rddata", u_if.umi_rddata_out, '0);
    u_if.umi_rden_in = 1'b0;
    tick();
    chk("abort_ctl_next", {u_if.umi_grant_out, u_if.umi_rdrdy_out, u_if.umi_wrrdy_out, busy}, 4'b0000);
    rst_n = 1'b1;
    tick();
    read_one(32'h100, rd, g);
    chk("post_rst_grant", g, 1'b1);
    chk("post_rst_mem", rd, D_B1);
    read_one(32'h0, rd, g);
    chk("post_rst_word0", rd, D_D2);

    // Size 0 read with raise held high
    base_rd = n_rdhs;
    base_gr = n_grant;
    req(1'b0, 32'h100, 32'd0);
    tick();
    chk("sz0_grant", u_if.umi_grant_out, 1'b1);
    u_if.umi_rden_in = 1'b1;
    tick();
    chk("sz0_nogrant_g1", u_if.umi_grant_out, 1'b0);
    tick();
    chk("sz0_beat", u_if.umi_rddata_out, D_B1);
    chk("sz0_nogrant_g2", u_if.umi_grant_out, 1'b0);
    tick();
    chk("sz0_idle_busy", busy, 1'b0);
    chk("sz0_idle_grant", u_if.umi_grant_out, 1'b0);
    chk("sz0_beats", 32'(n_rdhs - base_rd), 32'd1);
    tick();
    chk("sz0_regrant", u_if.umi_grant_out, 1'b1);
    u_if.umi_raise_in = 1'b0;
    tick();
    tick();
    tick();
    tick();
    u_if.umi_rden_in = 1'b0;
    chk("sz0_final_busy", busy, 1'b0);
    chk("sz0_grants", 32'(n_grant - base_gr), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/umi_responder.md
UMI_RESPONDER -- requirements
Module: umi_responder

Interface
REQ-001 Parameter NUM_WORDS, default 1024, sets backing-store depth in UMI_DATA_WIDTH-bit words; it SHALL be a power of two.
REQ-002 Parameter BEAT_BYTES, default UMI_DATA_WIDTH/8, sets bytes per beat.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port umi_raise_in  input  1  request valid from initiator.
REQ-006 Port umi_write_in  input  1  request is a write (1) or read (0).
REQ-007 Port umi_addr_in  input  UMI_ADDR_WIDTH  byte address of request.
REQ-008 Port umi_size_in  input  UMI_ADDR_WIDTH  request size in bytes.
REQ-009 Port umi_grant_out  output  1  one-cycle request acceptance pulse.
REQ-010 Port umi_rddata_out  output  UMI_DATA_WIDTH  read beat data.
REQ-011 Port umi_rdrdy_out  output  1  read beat valid.
REQ-012 Port umi_rden_in  input  1  initiator consumes read beat.
REQ-013 Port umi_wrdata_in  input  UMI_DATA_WIDTH  write beat data.
REQ-014 Port umi_wrmask_in  input  UMI_MASK_WIDTH  per-byte write suppress, 1 = byte not written.
REQ-015 Port umi_wren_in  input  1  write beat valid.
REQ-016 Port umi_wrrdy_out  output  1  responder can accept write beat.
REQ-017 Port busy_out  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, GRANT, READ, WRITE; IDLE->GRANT when umi_raise_in=1; GRANT->READ or WRITE per latched umi_write_in after exactly one cycle; READ/WRITE->IDLE on the handshake of the final beat.
REQ-019 umi_grant_out SHALL be 1 only in GRANT; addr, size and write SHALL be latched in the IDLE->GRANT cycle.
REQ-020 Beat count = ceil(size/BEAT_BYTES); size 0 SHALL be treated as one beat.
REQ-021 Start word index = addr / BEAT_BYTES (low bits ignored); each beat increments the index modulo NUM_WORDS (wrap-around, no error).
REQ-022 Read: backing store read is registered; first umi_rdrdy_out SHALL rise two cycles after the GRANT cycle; beats SHALL then stream one per cycle while umi_rden_in is held high (read-ahead skid buffer, depth 2).
REQ-023 Read beat handshake = umi_rdrdy_out & umi_rden_in; umi_rddata_out SHALL stay stable while umi_rdrdy_out=1 and umi_rden_in=0.
REQ-024 umi_rden_in while umi_rdrdy_out=0 SHALL be ignored.
REQ-025 Write: umi_wrrdy_out SHALL be 1 in every WRITE cycle; beat handshake = umi_wren_in & umi_wrrdy_out; data written in the same cycle.
REQ-026 umi_wren_in outside WRITE and umi_raise_in outside IDLE SHALL be ignored.
REQ-027 A read issued the cycle after a write completes SHALL return the newly written data.

Reset
REQ-028 On rst_n=0: FSM to IDLE; umi_grant_out, umi_rdrdy_out, umi_wrrdy_out, busy_out = 0; umi_rddata_out = 0; counters and skid buffer cleared.
REQ-029 Reset mid-transfer SHALL abort the transfer; backing-store contents SHALL NOT be cleared.

Configuration
REQ-030 Macro UMI_RESP_WRMASK_EN: when defined, bytes with umi_wrmask_in bit = 1 SHALL NOT be written; when undefined, umi_wrmask_in SHALL be ignored and all bytes written.

Structure
REQ-031 UMI_ADDR_WIDTH, UMI_DATA_WIDTH, UMI_MASK_WIDTH come from ShellTypes; the FSM state enum SHALL be added to ShellTypes.
REQ-032 Backing store SHALL be one sub-module umi_resp_ram (single-port, registered read, byte-enable write).

Verification
REQ-033 Write addr 0x0, size 128, beats 0xA5.., 0x5A.. -> one grant, two wrrdy handshakes, return to IDLE; read addr 0x0 size 128 -> rdrdy two cycles after grant, data 0xA5.. then 0x5A...
REQ-034 Read size 192 with umi_rden_in toggling 1,0,1,0 -> three beats delivered in order, data stable during stalls.
REQ-035 Write at word NUM_WORDS-1, size 128 -> second beat lands at word 0; read word 0 confirms.
REQ-036 With UMI_RESP_WRMASK_EN, write all-0xFF over all-0x00 with mask 0x1 -> byte 0 stays 0x00, bytes 1..63 read 0xFF; without macro all bytes 0xFF.
REQ-037 Assert rst_n=0 during beat 2 of a 4-beat read -> all outputs 0 next cycle, FSM IDLE; next request granted normally and prior memory contents intact.
REQ-038 Size 0 read -> exactly one beat; umi_raise_in held high during READ -> no second grant until IDLE.
